serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes Data_in_A - Data_in_B, least-significant bit first. It uses one full-subtractor cell and a registered borrow, and processes one bit per clock. It is the subtraction counterpart of the team's ripple adder cells and is intended for area-constrained datapaths that can accept WIDTH-cycle latency. A start/busy/done handshake controls each operation; the result stays in a holding register until the next operation completes.

---
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a registered borrow,
// LSB first, one bit per clock, with a start/busy/done handshake and result holding registers.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_in,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  output logic             Busy_out,
  output logic             Done_out,
  output logic [WIDTH-1:0] Data_out_Diff,
  output logic             Data_out_Borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             a_bit;
  logic             b_bit;
  logic             diff_bit;
  logic             borrow_next;
  logic             accept;

  // Full-subtractor cell fed by the operand LSBs and the registered borrow.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path through this block infers a latch.
    res_next    = res_sr >> 1;
    a_bit       = a_sr[0];
    b_bit       = b_sr[0];
    diff_bit    = a_bit ^ b_bit ^ borrow;
    borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    res_next[WIDTH-1] = diff_bit;
  end

  // A new operation may be accepted from IDLE or straight out of DONE.
  assign accept = Start_in && (state == IDLE || state == DONE);

  // NOTE: all state, including the operand/result shift registers, is cleared by reset and
  // updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      Busy_out        <= 1'b0;
      Done_out        <= 1'b0;
      Data_out_Diff   <= '0;
      Data_out_Borrow <= 1'b0;
      a_sr            <= '0;
      b_sr            <= '0;
      res_sr          <= '0;
      borrow          <= 1'b0;
      count           <= '0;
    end else if (accept) begin
      a_sr     <= Data_in_A;
      b_sr     <= Data_in_B;
      borrow   <= 1'b0;
      count    <= '0;
      state    <= RUN;
      Busy_out <= 1'b1;
      Done_out <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= borrow_next;
          count  <= count + 1'b1;
          if (count == LAST_BIT) begin
            Data_out_Diff   <= res_next;
            Data_out_Borrow <= borrow_next;
            state           <= DONE;
            Busy_out        <= 1'b0;
            Done_out        <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          Done_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          Busy_out <= 1'b0;
          Done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, bor8;
  logic       busy1, done1, bor1;
  logic [7:0] diff8;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Start_in(start8),
    .Data_in_A(a8), .Data_in_B(b8),
    .Busy_out(busy8), .Done_out(done8),
    .Data_out_Diff(diff8), .Data_out_Borrow(bor8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .Start_in(start1),
    .Data_in_A(a1), .Data_in_B(b1),
    .Busy_out(busy1), .Done_out(done1),
    .Data_out_Diff(diff1), .Data_out_Borrow(bor1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starting on a sampling point, count busy cycles until Done_out is seen (bounded).
  task automatic wait_done8(output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done8) got_done = 1'b1;
      else begin
        if (busy8) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int busy_cycles, output bit got_done);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    wait_done8(busy_cycles, got_done);
  endtask

  task automatic op1(input logic a, input logic b,
                     output int busy_cycles, output bit got_done);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b;
    @(negedge clk);
    start1 = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      if (done1) got_done = 1'b1;
      else begin
        if (busy1) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int         bc;
    bit         got;
    int         pulses;
    logic [7:0] hold_diff;
    logic       hold_bor;
    logic [7:0] ra, rb, ed;
    logic       sa, sb;

    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    reset  = 1'b1;
    #1;
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", bor8, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy8, 0);

    // 100 - 37: 8 busy cycles, then Done
    op8(8'd100, 8'd37, bc, got);
    check("t1_done_seen", got, 1);
    check("t1_busy_cycles", bc, 8);
    check("t1_diff", diff8, 8'd63);
    check("t1_borrow", bor8, 0);
    @(negedge clk);
    check("t1_done_one_cycle", done8, 0);

    op8(8'd5, 8'd9, bc, got);
    check("t2_done_seen", got, 1);
    check("t2_diff", diff8, 8'hFC);
    check("t2_borrow", bor8, 1);
    op8(8'h00, 8'h01, bc, got);
    check("t3_diff", diff8, 8'hFF);
    check("t3_borrow", bor8, 1);
    op8(8'hFF, 8'hFF, bc, got);
    check("t4_diff", diff8, 8'h00);
    check("t4_borrow", bor8, 0);

    // Start during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd50;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0; hold_diff = '0; hold_bor = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (done8) begin
        pulses++;
        hold_diff = diff8;
        hold_bor  = bor8;
      end
      @(negedge clk);
    end
    check("ign_pulses", pulses, 1);
    check("ign_diff", hold_diff, 8'd150);
    check("ign_borrow", hold_bor, 0);

    // Back-to-back: new start accepted in the DONE cycle
    op8(8'd20, 8'd5, bc, got);
    check("b2b_first_diff", diff8, 8'd15);
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy_rises", busy8, 1);
    check("b2b_done_low", done8, 0);
    check("b2b_holding", diff8, 8'd15);
    wait_done8(bc, got);
    check("b2b_done_seen", got, 1);
    check("b2b_busy_cycles", bc, 8);
    check("b2b_diff", diff8, 8'd7);
    check("b2b_borrow", bor8, 0);

    // Reset mid-RUN aborts and clears asynchronously
    op8(8'd9, 8'd4, bc, got);
    check("rst_pre_diff", diff8, 8'd5);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_run_busy", busy8, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_busy", busy8, 0);
    check("rst_async_done", done8, 0);
    check("rst_async_diff", diff8, 0);
    check("rst_async_borrow", bor8, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) pulses++;
      @(negedge clk);
    end
    check("rst_no_activity", pulses, 0);
    check("rst_hold_diff", diff8, 0);
    op8(8'd3, 8'd3, bc, got);
    check("rst_next_done", got, 1);
    check("rst_next_busy_cycles", bc, 8);
    check("rst_next_diff", diff8, 8'd0);
    check("rst_next_borrow", bor8, 0);

    // WIDTH=1 directed
    op1(1'b0, 1'b1, bc, got);
    check("w1_done_seen", got, 1);
    check("w1_busy_cycles", bc, 1);
    check("w1_diff", diff1, 1);
    check("w1_borrow", bor1, 1);

    // Randomized sweeps
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ed = ra - rb;
      op8(ra, rb, bc, got);
      check("rnd8_done", got, 1);
      check("rnd8_diff", diff8, ed);
      check("rnd8_borrow", bor8, (ra < rb) ? 1 : 0);
    end
    for (int n = 0; n < 1000; n++) begin
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      op1(sa, sb, bc, got);
      check("rnd1_done", got, 1);
      check("rnd1_diff", diff1, sa ^ sb);
      check("rnd1_borrow", bor1, (!sa && sb) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
